imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the ID stage.
- Decodes all RV32I/RV64I immediate formats: I, S, B, U, J and shift-amount.
- Sign-extends the immediate to XLEN and flags unsupported opcodes.
- Sits between the IF/ID register and the ID/EX register behind a valid/ready handshake. A 2-entry skid buffer absorbs EX-stage backpressure without a combinational ready path.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- SHW, derived from XLEN (5 for 32, 6 for 64), width of the shift-amount field.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset; asynchronous and active-high.
- flush_i  input  1  synchronous flush; drops all buffered entries.
- in_valid_i  input  1  inst_i is valid.
- in_ready_o  output  1  block can accept an instruction this cycle.
- inst_i  input  32  raw instruction word.
- out_valid_o  output  1  data_o, fmt_o and illegal_o are valid.
- out_ready_i  input  1  consumer accepts the output this cycle.
- data_o  output  XLEN  sign-extended (or zero-extended for shamt) immediate.
- fmt_o  output  3  format tag: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- illegal_o  output  1  opcode has no decode, or shamt out of range.

Behaviour:
- Decode (combinational on inst_i, captured on accept), by opcode = inst_i[6:0]:
  - 0000011 (load), 1100111 (jalr): I; imm = sext(inst[31:20]).
  - 0010011 with funct3 001 or 101: SHAMT; imm = zext(inst[20+SHW-1:20]). If XLEN=32 and inst[25]=1, set illegal_o=1 and imm=0.
  - 0010011 otherwise: I.
  - 0100011: S; imm = sext({inst[31:25], inst[11:7]}).
  - 1100011: B; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111, 0010111: U; imm = sext({inst[31:12], 12'b0}). For XLEN=64, bits 63:32 replicate inst[31].
  - 1101111: J; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Any other opcode: fmt_o=NONE, data_o=0, illegal_o=1. The entry is still passed downstream.
- Handshake:
  - Accept occurs when in_valid_i & in_ready_o.
  - Output transfer occurs when out_valid_o & out_ready_i.
  - Latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N, when the main register is empty or drains that cycle.
- Storage: main register (drives the outputs) plus one skid register.
  - in_ready_o is a registered signal, equal to "skid empty".
  - Main empty, or draining this cycle: the accepted entry goes to main.
  - Main full and not draining: the accepted entry goes to skid, and in_ready_o drops at the next edge.
  - When main drains with skid full: skid moves to main, and in_ready_o rises at the next edge.
  - Order is strictly FIFO. No entry is lost or duplicated.
- Output stability: while out_valid_o=1 and out_ready_i=0, data_o, fmt_o and illegal_o hold constant.
- flush_i (synchronous):
  - At the edge, main and skid are invalidated, out_valid_o=0 and in_ready_o=1.
  - An input presented in the same cycle is dropped.
  - Flush overrides accept and drain.
- Reset (rst_i=1, any time, including mid-stall):
  - Immediately: out_valid_o=0, data_o=0, fmt_o=0, illegal_o=0, in_ready_o=1, skid invalid.
  - The first accept is possible at the first rising clk_i after rst_i deasserts.
- Data registers do not toggle when no accept or skid move occurs.

Test Plan:
- XLEN=32, out_ready_i=1:
  - 0xFFF00093 (addi -1) -> next cycle data_o=0xFFFFFFFF, fmt_o=1, illegal_o=0.
  - 0xFE112E23 (sw x1,-4(x2)) -> data_o=0xFFFFFFFC, fmt_o=2.
- XLEN=32, out_ready_i=1:
  - 0xFE000CE3 (beq -8) -> data_o=0xFFFFFFF8, fmt_o=3.
  - 0x123450B7 (lui) -> data_o=0x12345000, fmt_o=4.
  - 0x4030D093 (srai 3) -> data_o=0x00000003, fmt_o=6.
  - 0x00000000 -> data_o=0, fmt_o=0, illegal_o=1.
- XLEN=64: 0x800000B7 (lui 0x80000) -> data_o=0xFFFFFFFF80000000. Shamt 0x03F0D093 -> data_o=63, illegal_o=0. The same word at XLEN=32 gives illegal_o=1.
- Backpressure:
  - Hold out_ready_i=0 and stream A, B, C back-to-back.
  - A is in main and B is in skid. in_ready_o=0 from the cycle after B, so C is held.
  - Raise out_ready_i: outputs are A, B, C in order, each exactly once, and data_o is stable while stalled.
- Flush with main and skid both full, plus a new in_valid_i in the same cycle -> next cycle out_valid_o=0, in_ready_o=1. The new instruction never appears.
- Assert rst_i asynchronously between edges during a stall -> outputs are zero and in_ready_o=1 immediately. After release, the first instruction appears with 1-cycle latency.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     inst_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] data_o;
    logic [2:0]      fmt_o;
    logic            illegal_o;

    modport slave (
        input  in_valid_i, inst_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, fmt_o, illegal_o
    );

    modport master (
        output in_valid_i, inst_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, fmt_o, illegal_o
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32I/RV64I immediate generator with 2-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    imm_gen_pipe_if.slave  bus
);
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    logic [31:0]        inst;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0]    dec_data;
    logic [2:0]         dec_fmt;
    logic               dec_ill;

    assign inst = bus.inst_i;

    // Each format is sign-extended to 32 bits first; the XLEN cast then extends once more for RV64.
    assign imm_i = 32'($signed(inst[31:20]));
    assign imm_s = 32'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = $signed({inst[31:12], 12'b0});
    assign imm_j = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    always_comb begin
        dec_data = '0;
        dec_fmt  = FMT_NONE;
        dec_ill  = 1'b0;
        case (inst[6:0])
            7'b0000011, 7'b1100111: begin
                dec_fmt  = FMT_I;
                dec_data = XLEN'(imm_i);
            end
            7'b0010011: begin
                if (inst[13:12] == 2'b01) begin
                    dec_fmt = FMT_SHAMT;
                    if (XLEN == 32 && inst[25]) begin
                        dec_ill = 1'b1;
                    end else begin
                        dec_data = XLEN'(inst[20+SHW-1:20]);
                    end
                end else begin
                    dec_fmt  = FMT_I;
                    dec_data = XLEN'(imm_i);
                end
            end
            7'b0100011: begin
                dec_fmt  = FMT_S;
                dec_data = XLEN'(imm_s);
            end
            7'b1100011: begin
                dec_fmt  = FMT_B;
                dec_data = XLEN'(imm_b);
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt  = FMT_U;
                dec_data = XLEN'(imm_u);
            end
            7'b1101111: begin
                dec_fmt  = FMT_J;
                dec_data = XLEN'(imm_j);
            end
            default: dec_ill = 1'b1;
        endcase
    end

    logic            main_valid, skid_valid;
    logic [XLEN-1:0] main_data, skid_data;
    logic [2:0]      main_fmt, skid_fmt;
    logic            main_ill, skid_ill;
    logic            accept, drain;

    // Ready is the registered skid-empty flag, so no combinational path from out_ready_i.
    assign accept = bus.in_valid_i & ~skid_valid;
    assign drain  = main_valid & bus.out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_fmt   <= FMT_NONE;
            main_ill   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_fmt   <= FMT_NONE;
            skid_ill   <= 1'b0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_fmt   <= skid_fmt;
                main_ill   <= skid_ill;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= dec_data;
                main_fmt   <= dec_fmt;
                main_ill   <= dec_ill;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= dec_data;
            skid_fmt   <= dec_fmt;
            skid_ill   <= dec_ill;
        end
    end

    assign bus.in_ready_o  = ~skid_valid;
    assign bus.out_valid_o = main_valid;
    assign bus.data_o      = main_data;
    assign bus.fmt_o       = main_fmt;
    assign bus.illegal_o   = main_ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe at XLEN=32 and XLEN=64
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst = 32'h0;

    int checks = 0;
    int failures = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) ifc32();
    imm_gen_pipe_if #(.XLEN(64)) ifc64();

    assign ifc32.in_valid_i  = in_valid;
    assign ifc32.inst_i      = inst;
    assign ifc32.out_ready_i = out_ready;
    assign ifc64.in_valid_i  = in_valid;
    assign ifc64.inst_i      = inst;
    assign ifc64.out_ready_i = out_ready;

    imm_gen_pipe #(.XLEN(32)) u_dut32 (.clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ifc32.slave));
    imm_gen_pipe #(.XLEN(64)) u_dut64 (.clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ifc64.slave));

    typedef struct {
        logic [31:0] inst;
        logic [31:0] d32;
        logic [2:0]  f32;
        logic        i32;
        logic [63:0] d64;
        logic [2:0]  f64;
        logic        i64;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic longint sx(input longint u, input int bits);
        if (u >= (longint'(1) << (bits - 1))) return u - (longint'(1) << bits);
        return u;
    endfunction

    // Reference decode from field arithmetic, independent of any bit-concatenation scheme.
    function automatic void ref_dec(input logic [31:0] w, input int xlen,
                                    output logic [63:0] d, output logic [2:0] f, output logic il);
        longint v;
        v = 0;
        f = 3'd0;
        il = 1'b0;
        case (w[6:0])
            7'h03, 7'h67: begin f = 3'd1; v = sx(longint'(w[31:20]), 12); end
            7'h13: begin
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                    f = 3'd6;
                    v = longint'(w[25:20]);
                    if (xlen == 32 && v >= 32) begin il = 1'b1; v = 0; end
                end else begin
                    f = 3'd1;
                    v = sx(longint'(w[31:20]), 12);
                end
            end
            7'h23: begin f = 3'd2; v = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12); end
            7'h63: begin
                f = 3'd3;
                v = sx(longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                       + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
            end
            7'h37, 7'h17: begin f = 3'd4; v = sx(longint'(w[31:12]) * 4096, 32); end
            7'h6F: begin
                f = 3'd5;
                v = sx(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                       + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
            end
            default: il = 1'b1;
        endcase
        d = 64'(v);
        if (xlen == 32) d = d & 64'h0000_0000_FFFF_FFFF;
    endfunction

    task automatic check_model();
        logic [63:0] d;
        logic [2:0]  f;
        logic        il;
        chk("out_valid32", 64'(ifc32.out_valid_o), 64'(q.size() > 0));
        chk("out_valid64", 64'(ifc64.out_valid_o), 64'(q.size() > 0));
        chk("in_ready32", 64'(ifc32.in_ready_o), 64'(q.size() < 2));
        chk("in_ready64", 64'(ifc64.in_ready_o), 64'(q.size() < 2));
        if (q.size() > 0) begin
            ref_dec(q[0], 32, d, f, il);
            chk("data32", 64'(ifc32.data_o), d);
            chk("fmt32", 64'(ifc32.fmt_o), 64'(f));
            chk("ill32", 64'(ifc32.illegal_o), 64'(il));
            ref_dec(q[0], 64, d, f, il);
            chk("data64", ifc64.data_o, d);
            chk("fmt64", 64'(ifc64.fmt_o), 64'(f));
            chk("ill64", 64'(ifc64.illegal_o), 64'(il));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid32"}, 64'(ifc32.out_valid_o), 64'd0);
        chk({tag, "_data32"}, 64'(ifc32.data_o), 64'd0);
        chk({tag, "_fmt32"}, 64'(ifc32.fmt_o), 64'd0);
        chk({tag, "_ill32"}, 64'(ifc32.illegal_o), 64'd0);
        chk({tag, "_ready32"}, 64'(ifc32.in_ready_o), 64'd1);
        chk({tag, "_valid64"}, 64'(ifc64.out_valid_o), 64'd0);
        chk({tag, "_data64"}, ifc64.data_o, 64'd0);
        chk({tag, "_ready64"}, 64'(ifc64.in_ready_o), 64'd1);
    endtask

    // Called at a negedge: drive, advance the occupancy model across the next posedge, then check.
    task automatic step(input logic v, input logic [31:0] w, input logic r, input logic f);
        logic acc, drn;
        in_valid = v;
        inst = w;
        out_ready = r;
        flush = f;
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && r;
        if (f) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(w);
        end
        @(negedge clk);
        check_model();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops[8];
        int          idx;
        ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h17};
        r = $urandom();
        idx = $urandom_range(0, 9);
        if (idx >= 8) return r;
        return {r[31:7], ops[idx]};
    endfunction

    localparam logic [31:0] INS_A = 32'hFFF00093;
    localparam logic [31:0] INS_B = 32'hFE112E23;
    localparam logic [31:0] INS_C = 32'h123450B7;
    localparam logic [31:0] INS_D = 32'hFE000CE3;

    initial begin
        vecs.push_back('{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0});
        vecs.push_back('{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0});
        vecs.push_back('{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0});
        vecs.push_back('{32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0});
        vecs.push_back('{32'h4030D093, 32'h00000003, 3'd6, 1'b0, 64'h0000000000000003, 3'd6, 1'b0});
        vecs.push_back('{32'h00000000, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1});
        vecs.push_back('{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0});
        vecs.push_back('{32'h03F0D093, 32'h00000000, 3'd6, 1'b1, 64'h000000000000003F, 3'd6, 1'b0});
        vecs.push_back('{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0});
        vecs.push_back('{32'h00812083, 32'h00000008, 3'd1, 1'b0, 64'h0000000000000008, 3'd1, 1'b0});
        vecs.push_back('{32'h01F09093, 32'h0000001F, 3'd6, 1'b0, 64'h000000000000001F, 3'd6, 1'b0});

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b1, vecs[i].inst, 1'b1, 1'b0);
            chk($sformatf("vec%0d_data32", i), 64'(ifc32.data_o), 64'(vecs[i].d32));
            chk($sformatf("vec%0d_fmt32", i), 64'(ifc32.fmt_o), 64'(vecs[i].f32));
            chk($sformatf("vec%0d_ill32", i), 64'(ifc32.illegal_o), 64'(vecs[i].i32));
            chk($sformatf("vec%0d_data64", i), ifc64.data_o, vecs[i].d64);
            chk($sformatf("vec%0d_fmt64", i), 64'(ifc64.fmt_o), 64'(vecs[i].f64));
            chk($sformatf("vec%0d_ill64", i), 64'(ifc64.illegal_o), 64'(vecs[i].i64));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: A in main, B in skid, C held until space frees up.
        step(1'b1, INS_A, 1'b0, 1'b0);
        chk("bp_a_data", 64'(ifc32.data_o), 64'hFFFFFFFF);
        step(1'b1, INS_B, 1'b0, 1'b0);
        chk("bp_ready_low", 64'(ifc32.in_ready_o), 64'd0);
        step(1'b1, INS_C, 1'b0, 1'b0);
        chk("bp_hold1", 64'(ifc32.data_o), 64'hFFFFFFFF);
        step(1'b1, INS_C, 1'b0, 1'b0);
        chk("bp_hold2", 64'(ifc32.data_o), 64'hFFFFFFFF);
        step(1'b1, INS_C, 1'b1, 1'b0);
        chk("bp_b_data", 64'(ifc32.data_o), 64'hFFFFFFFC);
        chk("bp_ready_high", 64'(ifc32.in_ready_o), 64'd1);
        step(1'b1, INS_C, 1'b1, 1'b0);
        chk("bp_c_data", 64'(ifc32.data_o), 64'h12345000);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_empty", 64'(ifc32.out_valid_o), 64'd0);

        // Flush with both entries full plus a same-cycle input.
        step(1'b1, INS_A, 1'b0, 1'b0);
        step(1'b1, INS_B, 1'b0, 1'b0);
        step(1'b1, INS_D, 1'b0, 1'b1);
        chk("flush_valid", 64'(ifc32.out_valid_o), 64'd0);
        chk("flush_ready", 64'(ifc32.in_ready_o), 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_no_d", 64'(ifc64.out_valid_o), 64'd0);

        // Asynchronous reset between edges during a stall.
        step(1'b1, INS_A, 1'b0, 1'b0);
        step(1'b1, INS_B, 1'b0, 1'b0);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1 check_reset("async_rst");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, INS_C, 1'b1, 1'b0);
        chk("post_rst_data", 64'(ifc32.data_o), 64'h12345000);
        chk("post_rst_valid", 64'(ifc32.out_valid_o), 64'd1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
